// File: rtl/fsm_bit_serializer_if.sv
// Word handshake into the bit serializer: the producer drives data/valid,
// and the serializer returns ready.
interface fsm_bit_serializer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial front end. Words enter a one-entry holding buffer and are
// shifted out one bit per programmable bit period. o_bit_stb flags the first
// cycle of every bit so that downstream FSMs can use it as a clock enable.
module fsm_bit_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIV_W     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    fsm_bit_serializer_if.slave    in_if,
    input  logic [DIV_W-1:0]       i_div,
    output logic                   o_x,
    output logic                   o_bit_stb,
    output logic                   o_busy,
    output logic                   o_word_done
);

    localparam int unsigned       CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LastBit = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_full_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [DIV_W-1:0]    div_reload_q;

    logic                xfer;
    logic                word_end;
    logic                load;
    logic                first_bit;
    logic                next_bit;
    logic [DATA_W-1:0]   shreg_shift;

    // Ready depends only on registered state and reset, never on the drain.
    assign in_if.ready = i_rst_n & ~hold_full_q;
    assign xfer        = in_if.valid & in_if.ready;
    assign word_end    = (state_q == StShift) && (div_cnt_q == '0) && (bit_cnt_q == LastBit);
    // Same load path from idle and at a word boundary, so back-to-back words have no gap.
    assign load        = hold_full_q && ((state_q == StIdle) || word_end);
    assign first_bit   = MSB_FIRST ? hold_q[DATA_W-1] : hold_q[0];

    // Shifter contents after dropping the bit currently on o_x.
    always_comb begin
        shreg_shift = '0;
        if (MSB_FIRST) begin
            shreg_shift = shreg_q << 1;
        end else begin
            shreg_shift = shreg_q >> 1;
        end
        next_bit = MSB_FIRST ? shreg_shift[DATA_W-1] : shreg_shift[0];
    end

    // Single FSM register block: hold buffer, shifter, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            div_reload_q <= '0;
            o_x          <= IDLE_BIT;
            o_bit_stb    <= 1'b0;
            o_busy       <= 1'b0;
            o_word_done  <= 1'b0;
        end else begin
            o_bit_stb   <= 1'b0;
            o_word_done <= word_end;

            if (load) begin
                state_q      <= StShift;
                shreg_q      <= hold_q;
                hold_full_q  <= 1'b0;
                bit_cnt_q    <= '0;
                div_cnt_q    <= i_div;
                div_reload_q <= i_div;
                o_x          <= first_bit;
                o_bit_stb    <= 1'b1;
                o_busy       <= 1'b1;
            end else if (state_q == StShift) begin
                if (div_cnt_q != '0) begin
                    div_cnt_q <= div_cnt_q - 1'b1;
                end else if (bit_cnt_q != LastBit) begin
                    shreg_q   <= shreg_shift;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    div_cnt_q <= div_reload_q;
                    o_x       <= next_bit;
                    o_bit_stb <= 1'b1;
                end else begin
                    state_q <= StIdle;
                    o_x     <= IDLE_BIT;
                    o_busy  <= 1'b0;
                end
            end

            // ready is low whenever hold is full, so this never collides with load.
            if (xfer) begin
                hold_q      <= in_if.data;
                hold_full_q <= 1'b1;
            end
        end
    end

endmodule
